// File: rtl/opc7_bus_ctrl_pkg.sv
// Shared types and constants for the opc7 downstream memory/IO bus controller.
// Holds the controller state encoding, the wait-counter width and the IO error fill word.
package opc7_bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH0  = 3'd1,
        PH1  = 3'd2,
        IO   = 3'd3,
        ACK  = 3'd4
    } bus_state_t;

    localparam int          MEM_WAIT_MIN = 1;
    localparam int          CNT_W        = 5;
    localparam logic [31:0] IO_ERR_FILL  = 32'hFFFF_FFFF;

    // Clamp an elaboration-time count into the 5-bit counter range.
    function automatic logic [CNT_W-1:0] cnt_sat(input int v);
        if (v <= 0) return '0;
        if (v >= (1 << CNT_W) - 1) return '1;
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/opc7_bus_ctrl_if.sv
// CPU-side, SRAM-side and IO-side signals of the opc7 bus controller.
// master = the controller; slave = the CPU core together with the SRAM and IO targets.
interface opc7_bus_ctrl_if;

    logic [19:0] cpu_address;
    logic        cpu_rnw;
    logic        cpu_vpa;
    logic        cpu_vda;
    logic        cpu_vio;
    logic [31:0] cpu_dout;
    logic [31:0] cpu_din;
    logic        cpu_clken;

    logic [20:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ce_b;
    logic        mem_oe_b;
    logic        mem_we_b;

    logic [7:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_rd;
    logic        io_wr;
    logic        io_ready;
    logic        bus_err;

    modport master (
        input  cpu_address, cpu_rnw, cpu_vpa, cpu_vda, cpu_vio, cpu_dout,
        output cpu_din, cpu_clken,
        output mem_addr, mem_wdata, mem_ce_b, mem_oe_b, mem_we_b,
        input  mem_rdata,
        output io_addr, io_wdata, io_rd, io_wr, bus_err,
        input  io_rdata, io_ready
    );

    modport slave (
        output cpu_address, cpu_rnw, cpu_vpa, cpu_vda, cpu_vio, cpu_dout,
        input  cpu_din, cpu_clken,
        input  mem_addr, mem_wdata, mem_ce_b, mem_oe_b, mem_we_b,
        output mem_rdata,
        input  io_addr, io_wdata, io_rd, io_wr, bus_err,
        output io_rdata, io_ready
    );

endinterface

// File: rtl/opc7_bus_ctrl_wait_cnt.sv
// Loadable 5-bit down-counter with zero flag; times SRAM phases and IO timeouts.
// Holds at zero instead of wrapping.
module opc7_wait_cnt
    import opc7_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/opc7_bus_ctrl.sv
// opc7 downstream bus stage: splits 32-bit memory words into two 16-bit SRAM transfers,
// runs IO accesses with a ready/timeout handshake and stalls the CPU via cpu_clken.
module opc7_bus_ctrl
    import opc7_bus_pkg::*;
#(
    parameter int MEM_WAIT   = 1,
    parameter int IO_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset,
    opc7_bus_ctrl_if.master bus
);

    localparam int               MW_EFF  = (MEM_WAIT < MEM_WAIT_MIN) ? MEM_WAIT_MIN : MEM_WAIT;
    localparam logic [CNT_W-1:0] PH_LOAD = cnt_sat(MW_EFF);
    localparam logic [CNT_W-1:0] IO_LOAD = cnt_sat(IO_TIMEOUT - 1);

    bus_state_t       state;
    logic             req;
    logic             rnw_q;
    logic [15:0]      dout_hi_q;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    assign req = bus.cpu_vpa | bus.cpu_vda | bus.cpu_vio;

    // Stall only while a request is being served; idle cycles and reset run the core freely.
    assign bus.cpu_clken = reset | ((state == IDLE) & ~req) | (state == ACK);

    // The counter is reloaded whenever the state is about to change.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state)
            IDLE: begin
                cnt_load = req;
                cnt_val  = bus.cpu_vio ? IO_LOAD : PH_LOAD;
            end
            PH0: begin
                cnt_load = cnt_zero;
                cnt_val  = PH_LOAD;
            end
            PH1:     cnt_load = cnt_zero;
            IO:      cnt_load = bus.io_ready | cnt_zero;
            ACK:     cnt_load = 1'b1;
            default: cnt_load = 1'b1;
        endcase
    end

    opc7_wait_cnt u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rnw_q        <= 1'b1;
            bus.cpu_din  <= '0;
            bus.mem_ce_b <= 1'b1;
            bus.mem_oe_b <= 1'b1;
            bus.mem_we_b <= 1'b1;
            bus.io_rd    <= 1'b0;
            bus.io_wr    <= 1'b0;
            bus.bus_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        rnw_q <= bus.cpu_rnw;
                        if (bus.cpu_vio) begin
                            state     <= IO;
                            bus.io_rd <= bus.cpu_rnw;
                            bus.io_wr <= ~bus.cpu_rnw;
                        end else begin
                            state        <= PH0;
                            bus.mem_ce_b <= 1'b0;
                            bus.mem_oe_b <= ~bus.cpu_rnw;
                            bus.mem_we_b <= 1'b1;
                        end
                    end
                end
                PH0: begin
                    if (cnt_zero) begin
                        state <= PH1;
                        if (rnw_q) begin
                            bus.cpu_din[15:0] <= bus.mem_rdata;
                        end else begin
                            // Writes deselect the SRAM for the PH1 setup cycle so the
                            // half-0 write cycle terminates before the address moves.
                            bus.mem_ce_b <= 1'b1;
                            bus.mem_we_b <= 1'b1;
                        end
                    end else begin
                        bus.mem_ce_b <= 1'b0;
                        bus.mem_we_b <= rnw_q;
                    end
                end
                PH1: begin
                    if (cnt_zero) begin
                        state        <= ACK;
                        bus.mem_ce_b <= 1'b1;
                        bus.mem_oe_b <= 1'b1;
                        bus.mem_we_b <= 1'b1;
                        if (rnw_q) bus.cpu_din[31:16] <= bus.mem_rdata;
                    end else begin
                        bus.mem_ce_b <= 1'b0;
                        bus.mem_we_b <= rnw_q;
                    end
                end
                IO: begin
                    if (bus.io_ready) begin
                        state       <= ACK;
                        bus.io_rd   <= 1'b0;
                        bus.io_wr   <= 1'b0;
                        bus.bus_err <= 1'b0;
                        if (rnw_q) bus.cpu_din <= bus.io_rdata;
                    end else if (cnt_zero) begin
                        state       <= ACK;
                        bus.io_rd   <= 1'b0;
                        bus.io_wr   <= 1'b0;
                        bus.bus_err <= 1'b1;
                        bus.cpu_din <= IO_ERR_FILL;
                    end
                end
                ACK: begin
                    state       <= IDLE;
                    bus.bus_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and write-data path: latched at request, advanced to half 1 between phases.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            bus.mem_addr  <= {bus.cpu_address, 1'b0};
            bus.mem_wdata <= bus.cpu_dout[15:0];
            dout_hi_q     <= bus.cpu_dout[31:16];
            bus.io_addr   <= bus.cpu_address[7:0];
            bus.io_wdata  <= bus.cpu_dout;
        end else if (state == PH0 && cnt_zero) begin
            bus.mem_addr  <= {bus.mem_addr[20:1], 1'b1};
            bus.mem_wdata <= dout_hi_q;
        end
    end

endmodule

// File: tb/tb_opc7_bus_ctrl.sv
// Scoreboard bench for opc7_bus_ctrl with a 64-halfword SRAM model and a delayed-ready IO target.
module tb_opc7_bus_ctrl;

    localparam int MEM_WAIT   = 1;
    localparam int IO_TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    opc7_bus_ctrl_if bus();

    opc7_bus_ctrl #(
        .MEM_WAIT   (MEM_WAIT),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] din;
        logic        err;
        int          lat;
        bit          chk_din;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    logic [15:0] sram   [0:63];
    int          we_cnt [0:63];
    bit          ready_en = 1'b0;
    int          io_delay = 0;
    int          io_cnt   = 0;
    int          io_seen  = 0;
    logic [1:0]  io_strb_seen;
    logic [7:0]  io_addr_seen;
    logic [31:0] io_wdata_seen;

    assign bus.mem_rdata = (!bus.mem_ce_b && !bus.mem_oe_b) ? sram[bus.mem_addr[5:0]] : 16'h0000;

    // SRAM write capture and IO target, both sampled mid-cycle.
    always @(negedge clk) begin
        if (!bus.mem_ce_b && !bus.mem_we_b) begin
            sram[bus.mem_addr[5:0]]   = bus.mem_wdata;
            we_cnt[bus.mem_addr[5:0]] = we_cnt[bus.mem_addr[5:0]] + 1;
        end
        if (bus.io_rd || bus.io_wr) begin
            io_cnt        = io_cnt + 1;
            io_seen       = io_cnt;
            io_strb_seen  = {bus.io_rd, bus.io_wr};
            io_addr_seen  = bus.io_addr;
            io_wdata_seen = bus.io_wdata;
            bus.io_ready  = ready_en && (io_cnt == io_delay);
        end else begin
            io_cnt       = 0;
            bus.io_ready = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_ack(input string tag, input logic [31:0] din, input logic err,
                              input int lat, input bit chk_din);
        exp_t e;
        e.tag     = tag;
        e.din     = din;
        e.err     = err;
        e.lat     = lat;
        e.chk_din = chk_din;
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic vpa, input logic vda, input logic vio, input logic rnw,
                             input logic [19:0] addr, input logic [31:0] dout);
        @(posedge clk);
        #1;
        bus.cpu_vpa     = vpa;
        bus.cpu_vda     = vda;
        bus.cpu_vio     = vio;
        bus.cpu_rnw     = rnw;
        bus.cpu_address = addr;
        bus.cpu_dout    = dout;
    endtask

    task automatic drop_req();
        bus.cpu_vpa = 1'b0;
        bus.cpu_vda = 1'b0;
        bus.cpu_vio = 1'b0;
    endtask

    // Latency counts the request cycle itself through the ACK cycle.
    task automatic wait_ack();
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cpu_clken && n < 100);
        e = sb.pop_front();
        chk({e.tag, "_lat"}, n, e.lat);
        if (e.chk_din) chk({e.tag, "_din"}, bus.cpu_din, e.din);
        chk({e.tag, "_err"}, {31'b0, bus.bus_err}, {31'b0, e.err});
        @(posedge clk);
        #1;
        drop_req();
        @(negedge clk);
        chk({e.tag, "_err_pulse"}, {31'b0, bus.bus_err}, 32'h0);
        chk({e.tag, "_idle_clken"}, {31'b0, bus.cpu_clken}, 32'h1);
    endtask

    initial begin
        reset           = 1'b0;
        bus.cpu_vpa     = 1'b0;
        bus.cpu_vda     = 1'b0;
        bus.cpu_vio     = 1'b0;
        bus.cpu_rnw     = 1'b1;
        bus.cpu_address = '0;
        bus.cpu_dout    = '0;
        bus.io_rdata    = '0;
        for (int i = 0; i < 64; i++) begin
            sram[i]   = 16'h0000;
            we_cnt[i] = 0;
        end
        sram[6'h20] = 16'h1234;
        sram[6'h21] = 16'hABCD;
        sram[6'h0B] = 16'h7777;
        #1 reset = 1'b1;

        // {clken, ce_b, oe_b, we_b, io_rd, io_wr} = 6'b111100 while in reset
        repeat (3) begin
            @(negedge clk);
            chk("rst_ctrl", {26'b0, bus.cpu_clken, bus.mem_ce_b, bus.mem_oe_b, bus.mem_we_b,
                             bus.io_rd, bus.io_wr}, 32'h3C);
            chk("rst_din", bus.cpu_din, 32'h0);
            chk("rst_err", {31'b0, bus.bus_err}, 32'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        expect_ack("rd", 32'hABCD1234, 1'b0, 6, 1'b1);
        drive_req(1'b1, 1'b0, 1'b0, 1'b1, 20'h00010, 32'h0);
        wait_ack();

        expect_ack("wr", 32'h0, 1'b0, 6, 1'b0);
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 20'h00003, 32'hDEADBEEF);
        wait_ack();
        chk("wr_lo_data", {16'h0, sram[6'h06]}, 32'h0000BEEF);
        chk("wr_hi_data", {16'h0, sram[6'h07]}, 32'h0000DEAD);
        chk("wr_lo_we_cycles", we_cnt[6'h06], MEM_WAIT);
        chk("wr_hi_we_cycles", we_cnt[6'h07], MEM_WAIT);

        expect_ack("rdback", 32'hDEADBEEF, 1'b0, 6, 1'b1);
        drive_req(1'b0, 1'b1, 1'b0, 1'b1, 20'h00003, 32'h0);
        wait_ack();

        ready_en     = 1'b1;
        io_delay     = 3;
        io_seen      = 0;
        bus.io_rdata = 32'h0000_0055;
        expect_ack("io_rd", 32'h0000_0055, 1'b0, 5, 1'b1);
        drive_req(1'b0, 1'b0, 1'b1, 1'b1, 20'h00042, 32'h0);
        wait_ack();
        chk("io_rd_addr", {24'h0, io_addr_seen}, 32'h42);
        chk("io_rd_strobe", {30'b0, io_strb_seen}, 32'h2);
        chk("io_rd_cycles", io_seen, 3);

        io_delay = 2;
        io_seen  = 0;
        expect_ack("io_wr", 32'h0, 1'b0, 4, 1'b0);
        drive_req(1'b0, 1'b0, 1'b1, 1'b0, 20'h0F1A3, 32'hCAFEF00D);
        wait_ack();
        chk("io_wr_addr", {24'h0, io_addr_seen}, 32'hA3);
        chk("io_wr_data", io_wdata_seen, 32'hCAFEF00D);
        chk("io_wr_strobe", {30'b0, io_strb_seen}, 32'h1);
        chk("io_wr_cycles", io_seen, 2);

        ready_en     = 1'b0;
        io_seen      = 0;
        bus.io_rdata = 32'h1234_5678;
        expect_ack("io_to", 32'hFFFFFFFF, 1'b1, IO_TIMEOUT + 2, 1'b1);
        drive_req(1'b0, 1'b0, 1'b1, 1'b1, 20'h00010, 32'h0);
        wait_ack();
        chk("io_to_cycles", io_seen, IO_TIMEOUT);

        ready_en     = 1'b1;
        io_delay     = IO_TIMEOUT;
        io_seen      = 0;
        bus.io_rdata = 32'h0BAD_F00D;
        expect_ack("io_edge", 32'h0BADF00D, 1'b0, IO_TIMEOUT + 2, 1'b1);
        drive_req(1'b0, 1'b0, 1'b1, 1'b1, 20'h00011, 32'h0);
        wait_ack();
        chk("io_edge_cycles", io_seen, IO_TIMEOUT);

        // Reset in the strobe-low cycle of a PH1 write.
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 20'h00005, 32'h11112222);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        chk("ph1_strobes_low", {30'b0, bus.mem_ce_b, bus.mem_we_b}, 32'h0);
        reset = 1'b1;
        drop_req();
        #1;
        chk("rst_async", {26'b0, bus.cpu_clken, bus.mem_ce_b, bus.mem_oe_b, bus.mem_we_b,
                          bus.io_rd, bus.io_wr}, 32'h3C);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("partial_lo_kept", {16'h0, sram[6'h0A]}, 32'h00002222);

        expect_ack("rd_after_rst", 32'h77772222, 1'b0, 6, 1'b1);
        drive_req(1'b1, 1'b0, 1'b0, 1'b1, 20'h00005, 32'h0);
        wait_ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
